led_status_engine: RTL

Next-generation miner status LED driver, replacing the fixed 8-LED work/result indicator. Tracks global miner state (idle / new work pending / working / result found) with a parametrised hold timer. Latches which hashing core produced a result. Drives a parametrised LED bank in one of four display modes. Sits at top level between the work dispatcher / core result strobes and the board LED pins.

---
 rtl/miner_led_pkg.sv | 16 +
 rtl/led_blink_gen.sv | 26 ++
 rtl/led_status_engine.sv | 102 ++++++++++
 3 files changed

// File: rtl/miner_led_pkg.sv
// Shared encodings for the miner status LED engine: FSM states and display modes.
package miner_led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_WORK_PENDING = 2'd1,
        ST_WORKING      = 2'd2,
        ST_RESULT       = 2'd3
    } state_t;

    localparam logic [1:0] MODE_LEGACY    = 2'd0;
    localparam logic [1:0] MODE_PER_CORE  = 2'd1;
    localparam logic [1:0] MODE_HEARTBEAT = 2'd2;
    localparam logic [1:0] MODE_OFF       = 2'd3;

endpackage

// File: rtl/led_blink_gen.sv
// Free-running blink phase generator: phase toggles every BLINK_CYCLES cycles.
module led_blink_gen #(
    parameter int unsigned BLINK_CYCLES = 25000000
) (
    input  logic clk,
    input  logic rst,
    output logic phase
);

    localparam int unsigned BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    logic [BW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == BW'(BLINK_CYCLES - 1)) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + BW'(1);
        end
    end

endmodule

// File: rtl/led_status_engine.sv
// Miner status LED driver: state FSM with hold timer, per-core result mask and LED decode.
module led_status_engine
    import miner_led_pkg::*;
#(
    parameter int unsigned NUM_LEDS     = 8,
    parameter int unsigned NUM_CORES    = 4,
    parameter int unsigned HOLD_CYCLES  = 100000000,
    parameter int unsigned BLINK_CYCLES = 25000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 new_work,
    input  logic [NUM_CORES-1:0] new_result,
    input  logic [1:0]           mode,
    output logic [NUM_LEDS-1:0]  led,
    output logic [1:0]           state_o
);

    localparam int unsigned CW = $clog2(HOLD_CYCLES);

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [NUM_CORES-1:0] mask;
    logic                 phase;
    logic                 pending;
    logic                 working;
    logic [NUM_LEDS-1:0]  bank;

    led_blink_gen #(
        .BLINK_CYCLES(BLINK_CYCLES)
    ) u_blink (
        .clk  (clk),
        .rst  (rst),
        .phase(phase)
    );

    // Results beat new work; timed states fall to WORKING after HOLD_CYCLES quiet cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            mask  <= '0;
        end else if (|new_result) begin
            state <= ST_RESULT;
            cnt   <= '0;
            mask  <= mask | new_result;
        end else if (new_work) begin
            state <= ST_WORK_PENDING;
            cnt   <= '0;
            mask  <= '0;
        end else begin
            case (state)
                ST_WORK_PENDING, ST_RESULT: begin
                    if (cnt == CW'(HOLD_CYCLES - 1)) begin
                        state <= ST_WORKING;
                        cnt   <= '0;
                        mask  <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    assign state_o = state;
    assign pending = (state == ST_WORK_PENDING) || (state == ST_RESULT);
    assign working = (state == ST_WORKING) || (state == ST_RESULT);

    // Bit 0 of bank is unused; led[0] mirrors reset directly.
    always_comb begin
        bank = '0;
        case (mode)
            MODE_LEGACY: begin
                for (int i = 1; i < NUM_LEDS; i++) begin
                    bank[i] = i[0] ? pending : working;
                end
            end
            MODE_PER_CORE: begin
                for (int i = 0; i < NUM_CORES; i++) begin
                    bank[i+1] = mask[i] & (state == ST_RESULT) & phase;
                end
                for (int i = NUM_CORES + 1; i < NUM_LEDS; i++) begin
                    bank[i] = working;
                end
            end
            MODE_HEARTBEAT: begin
                for (int i = 1; i < NUM_LEDS; i++) begin
                    bank[i] = working ? phase : pending;
                end
            end
            default: bank = '0;
        endcase
        if (rst) begin
            bank = '0;
        end
    end

    assign led = {bank[NUM_LEDS-1:1], rst};

endmodule
